// File: rtl/ifu_fetch_pkg.sv
// Shared definitions for the instruction fetch unit: bus widths, the NOP
// encoding, the default reset PC, FSM state encodings and the queue entry type.
package ifu_fetch_pkg;

    localparam int INST_ADDR_W = 32;
    localparam int INST_W      = 32;

    localparam logic [INST_W-1:0]      INST_NOP         = 32'h0000_0013;
    localparam logic [INST_ADDR_W-1:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [INST_ADDR_W-1:0] WORD_MASK        = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {
        IFU_RUN   = 1'b0,
        IFU_DRAIN = 1'b1
    } ifu_state_e;

    typedef struct packed {
        logic [INST_ADDR_W-1:0] pc;
        logic [INST_W-1:0]      inst;
    } ifu_entry_t;

endpackage

// File: rtl/ifu_fetch_buf.sv
// ifu_buf: small synchronous FIFO of {pc, inst} entries with clear.
// Clear wins over push/pop; push on a full FIFO is accepted only together
// with a pop. DEPTH must be a power of two (minimum 2).
module ifu_buf
    import ifu_fetch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic                     clear,
    input  ifu_entry_t               wdata,
    output ifu_entry_t               rdata,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty,
    output logic                     full
);

    localparam int              PW       = $clog2(DEPTH);
    localparam logic [PW:0]     CNT_FULL = (PW+1)'(DEPTH);

    ifu_entry_t      mem_r [DEPTH];
    logic [PW-1:0]   wptr_r;
    logic [PW-1:0]   rptr_r;
    logic [PW:0]     count_r;
    logic            do_pop_s;
    logic            do_push_s;

    assign empty     = (count_r == {(PW+1){1'b0}});
    assign full      = (count_r == CNT_FULL);
    assign count     = count_r;
    assign rdata     = mem_r[rptr_r];
    assign do_pop_s  = pop & ~empty;
    assign do_push_s = push & (~full | do_pop_s);

    // Entry storage: written at the tail on every accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= ifu_entry_t'(64'h0);
            end
        end else if (do_push_s && !clear) begin
            mem_r[wptr_r] <= wdata;
        end
    end

    // Pointers and occupancy; clear empties the FIFO in one cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {(PW+1){1'b0}};
        end else if (clear) begin
            wptr_r  <= {PW{1'b0}};
            rptr_r  <= {PW{1'b0}};
            count_r <= {(PW+1){1'b0}};
        end else begin
            if (do_push_s) begin
                wptr_r <= wptr_r + 1'b1;
            end
            if (do_pop_s) begin
                rptr_r <= rptr_r + 1'b1;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + 1'b1;
                2'b01:   count_r <= count_r - 1'b1;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction fetch unit feeding IF_ID.
// PC generation, req/gnt/rvalid bus handshake with credit-based flow control,
// in-order instruction queue (registered head + ifu_buf backing store),
// load-use hold and EX redirect with discard of in-flight responses.
// Optional build macro IFU_MISALIGN_EN: misaligned redirect targets raise
// if_misalign_o and stop fetching until the next redirect; without it the
// target's low two bits are ignored.
module ifu_fetch
    import ifu_fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = RESET_PC_DEFAULT,
    parameter int          BUF_DEPTH = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        hold_i,
    input  logic        jump_en_i,
    input  logic [31:0] jump_addr_i,
    output logic        ibus_req_o,
    output logic [31:0] ibus_addr_o,
    input  logic        ibus_gnt_i,
    input  logic        ibus_rvalid_i,
    input  logic [31:0] ibus_rdata_i,
    output logic        if_valid_o,
    output logic [31:0] if_inst_o,
    output logic [31:0] if_pc_o
`ifdef IFU_MISALIGN_EN
    ,
    output logic        if_misalign_o
`endif
);

    localparam int CW = $clog2(BUF_DEPTH) + 1;
    localparam int SW = CW + 1;

`ifdef IFU_MISALIGN_EN
    localparam logic [31:0] OUT_PC_MASK = 32'hFFFF_FFFF;
`else
    localparam logic [31:0] OUT_PC_MASK = WORD_MASK;
`endif

    // Registered state
    ifu_state_e     state_r;
    logic [31:0]    fetch_pc_r;
    logic [31:0]    resp_pc_r;
    logic           req_r;
    logic [CW-1:0]  outst_r;
    logic [CW-1:0]  drop_r;
    logic           out_valid_r;
    logic [31:0]    out_pc_r;
    logic [31:0]    out_inst_r;

    // Next-state and control
    ifu_state_e     state_next_s;
    logic [31:0]    fetch_pc_next_s;
    logic [31:0]    resp_pc_next_s;
    logic           req_next_s;
    logic [CW-1:0]  outst_next_s;
    logic [CW-1:0]  drop_next_s;
    logic           out_valid_next_s;
    logic [31:0]    out_pc_next_s;
    logic [31:0]    out_inst_next_s;
    logic [CW-1:0]  buf_cnt_next_s;
    logic [SW-1:0]  credit_sum_s;
    logic           grant_s;
    logic           push_s;
    logic           discard_s;
    logic           bypass_s;
    logic           buf_push_s;
    logic           buf_pop_s;
    logic           misalign_s;
    logic           misalign_next_s;

    // Queue backing store
    ifu_entry_t     buf_wdata_s;
    ifu_entry_t     buf_rdata_s;
    logic [CW-1:0]  buf_count_s;
    logic           buf_empty_s;
    logic           buf_full_s;

    assign grant_s     = req_r & ibus_gnt_i;
    assign push_s      = ibus_rvalid_i & (state_r == IFU_RUN) & ~jump_en_i;
    assign discard_s   = ibus_rvalid_i & (state_r == IFU_DRAIN);
    assign bypass_s    = push_s & ~hold_i & buf_empty_s;
    assign buf_pop_s   = ~jump_en_i & ~hold_i & ~buf_empty_s;
    assign buf_push_s  = push_s & ~bypass_s & (~buf_full_s | buf_pop_s);
    assign buf_wdata_s = '{pc: resp_pc_r, inst: ibus_rdata_i};

`ifdef IFU_MISALIGN_EN
    logic misalign_r;
    assign misalign_s      = misalign_r;
    assign misalign_next_s = jump_en_i ? (|jump_addr_i[1:0]) : misalign_r;
    assign if_misalign_o   = misalign_r;

    // Misalign flag: set by a misaligned redirect, cleared by the next redirect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            misalign_r <= 1'b0;
        end else begin
            misalign_r <= misalign_next_s;
        end
    end
`else
    assign misalign_s      = 1'b0;
    assign misalign_next_s = 1'b0;
`endif

    ifu_buf #(
        .DEPTH (BUF_DEPTH)
    ) u_buf (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (buf_push_s),
        .pop   (buf_pop_s),
        .clear (jump_en_i),
        .wdata (buf_wdata_s),
        .rdata (buf_rdata_s),
        .count (buf_count_s),
        .empty (buf_empty_s),
        .full  (buf_full_s)
    );

    // Next-state: bus accounting, redirect handling, head register and credit.
    always_comb begin
        outst_next_s     = outst_r + {{(CW-1){1'b0}}, grant_s}
                                   - {{(CW-1){1'b0}}, ibus_rvalid_i};
        drop_next_s      = drop_r;
        state_next_s     = state_r;
        fetch_pc_next_s  = fetch_pc_r;
        resp_pc_next_s   = resp_pc_r;
        out_valid_next_s = out_valid_r;
        out_pc_next_s    = out_pc_r;
        out_inst_next_s  = out_inst_r;
        buf_cnt_next_s   = buf_count_s;

        // Drop bookkeeping: a redirect discards everything still in flight.
        if (jump_en_i) begin
            drop_next_s = outst_next_s;
        end else if (discard_s) begin
            drop_next_s = drop_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            drop_next_s = drop_r;
        end

        if (drop_next_s != {CW{1'b0}}) begin
            state_next_s = IFU_DRAIN;
        end else begin
            state_next_s = IFU_RUN;
        end

        // Fetch address and the PC expected for the next kept response.
        if (jump_en_i) begin
            fetch_pc_next_s = jump_addr_i & WORD_MASK;
            resp_pc_next_s  = jump_addr_i & WORD_MASK;
        end else begin
            if (grant_s) begin
                fetch_pc_next_s = fetch_pc_r + 32'd4;
            end else begin
                fetch_pc_next_s = fetch_pc_r;
            end
            if (push_s) begin
                resp_pc_next_s = resp_pc_r + 32'd4;
            end else begin
                resp_pc_next_s = resp_pc_r;
            end
        end

        // Head register: frozen under hold, refilled from buffer or bypass.
        if (jump_en_i) begin
            out_valid_next_s = 1'b0;
            out_pc_next_s    = jump_addr_i & OUT_PC_MASK;
            out_inst_next_s  = INST_NOP;
        end else if (hold_i) begin
            out_valid_next_s = out_valid_r;
            out_pc_next_s    = out_pc_r;
            out_inst_next_s  = out_inst_r;
        end else if (!buf_empty_s) begin
            out_valid_next_s = 1'b1;
            out_pc_next_s    = buf_rdata_s.pc;
            out_inst_next_s  = buf_rdata_s.inst;
        end else if (push_s) begin
            out_valid_next_s = 1'b1;
            out_pc_next_s    = resp_pc_r;
            out_inst_next_s  = ibus_rdata_i;
        end else begin
            out_valid_next_s = 1'b0;
            out_pc_next_s    = out_pc_r;
            out_inst_next_s  = INST_NOP;
        end

        // Backing-store occupancy after this cycle.
        if (jump_en_i) begin
            buf_cnt_next_s = {CW{1'b0}};
        end else begin
            case ({buf_push_s, buf_pop_s})
                2'b10:   buf_cnt_next_s = buf_count_s + {{(CW-1){1'b0}}, 1'b1};
                2'b01:   buf_cnt_next_s = buf_count_s - {{(CW-1){1'b0}}, 1'b1};
                default: buf_cnt_next_s = buf_count_s;
            endcase
        end

        // Credit: outstanding plus queued never exceeds the queue depth.
        credit_sum_s = {1'b0, outst_next_s} + {1'b0, buf_cnt_next_s}
                     + {{(SW-1){1'b0}}, out_valid_next_s};
        if ((credit_sum_s < SW'(BUF_DEPTH)) && !misalign_next_s) begin
            req_next_s = 1'b1;
        end else begin
            req_next_s = 1'b0;
        end
    end

    // Fetch-side and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r     <= IFU_RUN;
            fetch_pc_r  <= RESET_PC & WORD_MASK;
            resp_pc_r   <= RESET_PC & WORD_MASK;
            req_r       <= 1'b0;
            outst_r     <= {CW{1'b0}};
            drop_r      <= {CW{1'b0}};
            out_valid_r <= 1'b0;
            out_pc_r    <= RESET_PC;
            out_inst_r  <= INST_NOP;
        end else begin
            state_r     <= state_next_s;
            fetch_pc_r  <= fetch_pc_next_s;
            resp_pc_r   <= resp_pc_next_s;
            req_r       <= req_next_s & ~misalign_s | req_next_s & jump_en_i;
            outst_r     <= outst_next_s;
            drop_r      <= drop_next_s;
            out_valid_r <= out_valid_next_s;
            out_pc_r    <= out_pc_next_s;
            out_inst_r  <= out_inst_next_s;
        end
    end

    assign ibus_req_o  = req_r;
    assign ibus_addr_o = fetch_pc_r;
    assign if_valid_o  = out_valid_r;
    assign if_inst_o   = out_inst_r;
    assign if_pc_o     = out_pc_r;

endmodule

// File: tb/tb_ifu_fetch.sv
// Directed bench for ifu_fetch: stream, hold, redirects, delayed grant,
// mid-run reset, PC wrap and redirect-target alignment / misalign flag.
module tb_ifu_fetch;

    logic        clk;
    logic        rst_n;
    logic        hold_i;
    logic        jump_en_i;
    logic [31:0] jump_addr_i;
    logic        ibus_req_o;
    logic [31:0] ibus_addr_o;
    logic        ibus_gnt_i;
    logic        ibus_rvalid_i;
    logic [31:0] ibus_rdata_i;
    logic        if_valid_o;
    logic [31:0] if_inst_o;
    logic [31:0] if_pc_o;
`ifdef IFU_MISALIGN_EN
    logic        if_misalign_o;
`endif

    int n_checks = 0;
    int n_fails  = 0;

    ifu_fetch dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .hold_i        (hold_i),
        .jump_en_i     (jump_en_i),
        .jump_addr_i   (jump_addr_i),
        .ibus_req_o    (ibus_req_o),
        .ibus_addr_o   (ibus_addr_o),
        .ibus_gnt_i    (ibus_gnt_i),
        .ibus_rvalid_i (ibus_rvalid_i),
        .ibus_rdata_i  (ibus_rdata_i),
        .if_valid_o    (if_valid_o),
        .if_inst_o     (if_inst_o),
        .if_pc_o       (if_pc_o)
`ifdef IFU_MISALIGN_EN
        ,
        .if_misalign_o (if_misalign_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic g, input logic rv, input logic [31:0] rd);
        ibus_gnt_i    = g;
        ibus_rvalid_i = rv;
        ibus_rdata_i  = rd;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    initial begin
        rst_n = 1'b0; hold_i = 1'b0; jump_en_i = 1'b0; jump_addr_i = 32'h0;
        drive(1'b0, 1'b0, 32'h0);
        tick(); tick();
        check("rst_req",   {31'h0, ibus_req_o}, 32'h0);
        check("rst_valid", {31'h0, if_valid_o}, 32'h0);
        check("rst_inst",  if_inst_o,   32'h0000_0013);
        check("rst_pc",    if_pc_o,     32'h0000_0000);
        check("rst_addr",  ibus_addr_o, 32'h0000_0000);

        // Streaming with gnt always high, response one cycle after gnt
        rst_n = 1'b1; drive(1'b1, 1'b0, 32'h0); tick();
        check("s_req1",   {31'h0, ibus_req_o}, 32'h1);
        check("s_addr0",  ibus_addr_o, 32'h0);
        drive(1'b1, 1'b0, 32'h0); tick();
        check("s_val_early", {31'h0, if_valid_o}, 32'h0);
        check("s_addr4",  ibus_addr_o, 32'h4);
        drive(1'b1, 1'b1, 32'h1000_0000); tick();
        check("s_val0",   {31'h0, if_valid_o}, 32'h1);
        check("s_pc0",    if_pc_o,   32'h0);
        check("s_inst0",  if_inst_o, 32'h1000_0000);
        check("s_credit", {31'h0, ibus_req_o}, 32'h0);
        drive(1'b1, 1'b1, 32'h1000_0004); tick();
        check("s_pc4",    if_pc_o,   32'h4);
        check("s_inst4",  if_inst_o, 32'h1000_0004);
        check("s_req_back", {31'h0, ibus_req_o}, 32'h1);
        check("s_addr8",  ibus_addr_o, 32'h8);
        drive(1'b1, 1'b0, 32'h0); tick();
        check("s_bubble", {31'h0, if_valid_o}, 32'h0);
        check("s_addr12", ibus_addr_o, 32'hC);
        drive(1'b1, 1'b1, 32'h1000_0008); tick();
        check("s_pc8",    if_pc_o, 32'h8);

        // Hold for 3 cycles while the response for 12 arrives
        hold_i = 1'b1; drive(1'b1, 1'b1, 32'h1000_000C); tick();
        check("h_pc_0",   if_pc_o,   32'h8);
        check("h_inst_0", if_inst_o, 32'h1000_0008);
        check("h_req_0",  {31'h0, ibus_req_o}, 32'h0);
        for (int i = 1; i < 3; i++) begin
            drive(1'b1, 1'b0, 32'h0); tick();
            check($sformatf("h_pc_%0d", i),   if_pc_o,   32'h8);
            check($sformatf("h_inst_%0d", i), if_inst_o, 32'h1000_0008);
            check($sformatf("h_val_%0d", i),  {31'h0, if_valid_o}, 32'h1);
            check($sformatf("h_req_%0d", i),  {31'h0, ibus_req_o}, 32'h0);
        end
        hold_i = 1'b0; drive(1'b1, 1'b0, 32'h0); tick();
        check("h_resume_pc",   if_pc_o,   32'hC);
        check("h_resume_inst", if_inst_o, 32'h1000_000C);
        check("h_resume_addr", ibus_addr_o, 32'h10);

        // Redirect to 0x100 with two responses outstanding (16, 20)
        drive(1'b1, 1'b0, 32'h0); tick();
        check("j_pre_val", {31'h0, if_valid_o}, 32'h0);
        drive(1'b1, 1'b0, 32'h0); tick();
        check("j_two_out", {31'h0, ibus_req_o}, 32'h0);
        jump_en_i = 1'b1; jump_addr_i = 32'h100; drive(1'b0, 1'b0, 32'h0); tick();
        check("j_val_a",  {31'h0, if_valid_o}, 32'h0);
        check("j_addr",   ibus_addr_o, 32'h100);
        jump_en_i = 1'b0; drive(1'b0, 1'b1, 32'h1000_0010); tick();
        check("j_drop1",  {31'h0, if_valid_o}, 32'h0);
        check("j_req",    {31'h0, ibus_req_o}, 32'h1);
        drive(1'b1, 1'b1, 32'h1000_0014); tick();
        check("j_drop2",  {31'h0, if_valid_o}, 32'h0);
        check("j_addr2",  ibus_addr_o, 32'h104);
        drive(1'b1, 1'b1, 32'h1000_0100); tick();
        check("j_val",    {31'h0, if_valid_o}, 32'h1);
        check("j_pc",     if_pc_o,   32'h100);
        check("j_inst",   if_inst_o, 32'h1000_0100);

        // Redirect and hold in the same cycle
        hold_i = 1'b1; jump_en_i = 1'b1; jump_addr_i = 32'h180;
        drive(1'b1, 1'b1, 32'h1000_0104); tick();
        check("jh_val",   {31'h0, if_valid_o}, 32'h0);
        check("jh_addr",  ibus_addr_o, 32'h180);
        check("jh_req",   {31'h0, ibus_req_o}, 32'h1);
        hold_i = 1'b0; jump_en_i = 1'b0; drive(1'b1, 1'b0, 32'h0); tick();
        check("jh_gap",   {31'h0, if_valid_o}, 32'h0);
        drive(1'b0, 1'b1, 32'h1000_0180); tick();
        check("jh_pc",    if_pc_o,   32'h180);
        check("jh_inst",  if_inst_o, 32'h1000_0180);

        // Delayed grant: address/request stable for 4 cycles
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 32'h0); tick();
            check($sformatf("g_req_%0d", i),  {31'h0, ibus_req_o}, 32'h1);
            check($sformatf("g_addr_%0d", i), ibus_addr_o, 32'h184);
        end
        rst_n = 1'b0; #1;
        check("r_req",   {31'h0, ibus_req_o}, 32'h0);
        check("r_pc",    if_pc_o,     32'h0);
        check("r_addr",  ibus_addr_o, 32'h0);
        check("r_val",   {31'h0, if_valid_o}, 32'h0);
        tick(); rst_n = 1'b1;
        drive(1'b0, 1'b0, 32'h0); tick();
        check("r_req_up", {31'h0, ibus_req_o}, 32'h1);

        // PC wrap-around
        jump_en_i = 1'b1; jump_addr_i = 32'hFFFF_FFFC; drive(1'b0, 1'b0, 32'h0); tick();
        check("w_addr_top", ibus_addr_o, 32'hFFFF_FFFC);
        jump_en_i = 1'b0; drive(1'b1, 1'b0, 32'h0); tick();
        check("w_addr_wrap", ibus_addr_o, 32'h0);
        check("w_req",       {31'h0, ibus_req_o}, 32'h1);

`ifdef IFU_MISALIGN_EN
        jump_en_i = 1'b1; jump_addr_i = 32'h102; drive(1'b0, 1'b0, 32'h0); tick();
        check("m_flag",  {31'h0, if_misalign_o}, 32'h1);
        check("m_req",   {31'h0, ibus_req_o}, 32'h0);
        check("m_pc",    if_pc_o, 32'h102);
        check("m_val",   {31'h0, if_valid_o}, 32'h0);
        jump_en_i = 1'b0; drive(1'b0, 1'b1, 32'h1000_0000); tick();
        check("m_stop",  {31'h0, ibus_req_o}, 32'h0);
        check("m_flag2", {31'h0, if_misalign_o}, 32'h1);
        jump_en_i = 1'b1; jump_addr_i = 32'h200; drive(1'b0, 1'b0, 32'h0); tick();
        check("m_clear", {31'h0, if_misalign_o}, 32'h0);
        check("m_addr",  ibus_addr_o, 32'h200);
        check("m_req2",  {31'h0, ibus_req_o}, 32'h1);
        jump_en_i = 1'b0; drive(1'b1, 1'b0, 32'h0); tick();
        drive(1'b0, 1'b1, 32'h1000_0200); tick();
        check("m_pc200", if_pc_o, 32'h200);
        check("m_val2",  {31'h0, if_valid_o}, 32'h1);
`else
        jump_en_i = 1'b1; jump_addr_i = 32'h206; drive(1'b0, 1'b0, 32'h0); tick();
        check("a_addr",  ibus_addr_o, 32'h204);
        check("a_req",   {31'h0, ibus_req_o}, 32'h1);
        jump_en_i = 1'b0; drive(1'b1, 1'b1, 32'h1000_0000); tick();
        check("a_drop",  {31'h0, if_valid_o}, 32'h0);
        drive(1'b0, 1'b1, 32'h1000_0204); tick();
        check("a_pc",    if_pc_o,   32'h204);
        check("a_inst",  if_inst_o, 32'h1000_0204);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
